// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM states and lane count for dmem_ctrl.
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  localparam int LANES = 4;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store byte enables/replicated data and load extraction with extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]       size,
  input  logic [1:0]       lo,
  input  logic             sgn,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rword,
  output logic [LANES-1:0] be,
  output logic [31:0]      wrep,
  output logic [31:0]      rdata
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b     = rword[{lo, 3'b000} +: 8];
    h     = lo[1] ? rword[31:16] : rword[15:0];
    be    = size == SZ_BYTE ? 4'b0001 << lo :
            size == SZ_HALF ? (lo[1] ? 4'b1100 : 4'b0011) :
            size == SZ_WORD ? 4'b1111 : 4'b0000;
    wrep  = size == SZ_BYTE ? {4{wdata[7:0]}} :
            size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    rdata = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
            size == SZ_HALF ? {{16{sgn & h[15]}}, h} :
            size == SZ_WORD ? rword : '0;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed data memory, zero-filled after reset, one-cycle registered response.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  state_t           state;
  logic [IW-1:0]    cnt;
  logic [31:0]      mem [DEPTH_WORDS];
  logic [IW-1:0]    idx;
  logic             oor, mis, err, acc;
  logic [LANES-1:0] be;
  logic [31:0]      wrep, ld;
  assign idx       = req_addr[IW+1:2];
  assign oor       = {1'b0, req_addr} >= (ADDR_W+1)'(4 * DEPTH_WORDS);
`ifdef DMEM_ALIGN_CHECK_EN
  assign mis       = (req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
  assign mis       = 1'b0;
`endif
  assign err       = oor | (req_size == SZ_RSVD) | mis;
  assign req_ready = state == ST_RUN;
  assign acc       = req_valid & req_ready;
  dmem_lane_align u_align (
    .size  (req_size),
    .lo    (req_addr[1:0]),
    .sgn   (req_signed),
    .wdata (req_wdata),
    .rword (mem[idx]),
    .be    (be),
    .wrep  (wrep),
    .rdata (ld)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= (state == ST_INIT && cnt == IW'(DEPTH_WORDS - 1)) ? ST_RUN : state;
      cnt       <= state == ST_INIT ? cnt + 1'b1 : cnt;
      rsp_valid <= acc;
      rsp_err   <= acc & err;
      rsp_rdata <= (acc && !err && !req_write) ? ld : '0;
    end
  end
  // Storage has no reset of its own; INIT sweeps it to zero instead.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_INIT)
      mem[cnt] <= '0;
    else if (!rst && acc && req_write && !err)
      for (int k = 0; k < LANES; k++)
        if (be[k]) mem[idx][8*k +: 8] <= wrep[8*k +: 8];
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl against a byte-array reference model.
module tb_dmem_ctrl;
  import dmem_pkg::*;
  localparam int DEPTH = 256;
  localparam int BYTES = 4 * DEPTH;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {int due; logic err; logic [31:0] data;} exp_t;
  exp_t q[$];
  logic [7:0] ref_mem [BYTES];
  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endfunction
  // Reference: a flat byte array, accesses addressed at the naturally aligned base.
  function automatic exp_t model(bit w, logic [1:0] sz, bit sg, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    int n;
    int base;
    logic [31:0] v;
    bit bad;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    bad = (a >= BYTES) || sz == 2'd3;
`ifdef DMEM_ALIGN_CHECK_EN
    bad = bad || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`endif
    e.due = 0; e.err = bad; e.data = '0;
    if (bad) return e;
    base = int'(a) - (int'(a) % n);
    v = '0;
    for (int i = 0; i < n; i++)
      if (w) ref_mem[base+i] = wd[8*i +: 8];
      else v[8*i +: 8] = ref_mem[base+i];
    if (!w && sg && n == 1 && v[7]) v[31:8] = '1;
    if (!w && sg && n == 2 && v[15]) v[31:16] = '1;
    e.data = w ? 32'h0 : v;
    return e;
  endfunction
  // Called at posedge+#1; the request is accepted at the next edge if ready.
  task automatic send(bit w, logic [1:0] sz, bit sg, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    if (req_ready) begin
      e = model(w, sz, sg, a, wd);
      e.due = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask
  task automatic idle(int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      bit want;
      want = q.size() > 0 && q[0].due <= cyc;
      chk("rsp_valid", 32'(rsp_valid), 32'(want));
      if (want) begin
        e = q.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_rdata", rsp_rdata, e.data);
      end
    end
  end
  task automatic count_init(string name);
    int n = 0;
    while (!req_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, DEPTH);
  endtask
  initial begin
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 0);
    chk("reset_valid", 32'(rsp_valid), 0);
    chk("reset_rdata", rsp_rdata, 0);
    chk("reset_err", 32'(rsp_err), 0);
    rst = 1'b0;
    repeat (100) begin @(posedge clk); #1; end
    chk("mid_init_ready", 32'(req_ready), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", 32'(req_ready), 0);
    chk("rst_mid_valid", 32'(rsp_valid), 0);
    rst = 1'b0;
    count_init("init_cycles_after_reset");
    send(0, SZ_WORD, 0, 32'h3FC, 0);
    send(1, SZ_WORD, 0, 32'h10, 32'h8899AABB);
    send(0, SZ_BYTE, 1, 32'h11, 0);
    send(0, SZ_HALF, 0, 32'h12, 0);
    send(1, SZ_WORD, 0, 32'h20, 32'h11223344);
    send(1, SZ_BYTE, 0, 32'h22, 32'h000000EE);
    send(0, SZ_WORD, 0, 32'h20, 0);
    idle(1);
    send(1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D);
    send(0, SZ_WORD, 0, 32'h40, 0);
    send(0, SZ_WORD, 0, 32'h400, 0);
    send(1, SZ_RSVD, 0, 32'h40, 32'h12345678);
    send(0, SZ_WORD, 0, 32'h40, 0);
    send(0, SZ_WORD, 0, 32'h42, 0);
    send(0, SZ_HALF, 1, 32'h43, 0);
    send(1, SZ_HALF, 0, 32'h3FF, 32'hBEEF);
    send(0, SZ_WORD, 0, 32'h3FC, 0);
    send(0, SZ_BYTE, 0, 32'hFFFFFFFF, 0);
    idle(2);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [1:0] sz;
      a = ($urandom % 16 == 0) ? 32'(BYTES + $urandom_range(0, 4000)) : 32'($urandom_range(0, BYTES - 1));
      sz = ($urandom % 16 == 0) ? SZ_RSVD : 2'($urandom_range(0, 2));
      if ($urandom % 4 == 0) idle(1);
      else send(1'($urandom), sz, 1'($urandom), a, $urandom);
    end
    idle(3);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised, synchronous byte-addressed data memory for the MIPS datapath, the successor to the word-only data memory. Supports byte, halfword and word loads and stores with byte-lane enables and signed/unsigned load extension. Uses a valid/ready request port with a one-cycle registered response. Zero-fills its storage after reset and flags out-of-range accesses.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; must be a power of two and at least 4.
- `ADDR_W`, default 32: byte-address width.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request this cycle.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: access size; 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` input 1: sign-extend loaded byte/half; ignored for word and stores.
- `req_addr` input ADDR_W: byte address.
- `req_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` output 1: one-cycle pulse; response for the accepted request.
- `rsp_rdata` output 32: load result, extended to 32 bits; 0 for stores and errors.
- `rsp_err` output 1: access rejected (out of range, reserved size, or misaligned when the check is enabled).

## Operation
- Storage: DEPTH_WORDS × 32-bit words, four byte lanes, little-endian. Byte k of a word is at byte address 4·index+k.
- Word index is `req_addr[log2(DEPTH_WORDS)+1:2]`.
- FSM states: INIT and RUN.
  - INIT: a counter steps from 0 to DEPTH_WORDS−1 and writes zero to one word per cycle. `req_ready`=0.
  - When the counter reaches DEPTH_WORDS−1, the FSM moves to RUN.
  - RUN: `req_ready`=1 every cycle.
- Handshake: a request is accepted when `req_valid && req_ready`. Requests presented while `req_ready`=0 are ignored and must be held by the requester.
- Store byte enables:
  - Byte: lane `addr[1:0]`.
  - Half: lanes {1,0} when `addr[1]`=0, lanes {3,2} when `addr[1]`=1.
  - Word: all lanes.
  - Store data is replicated onto the selected lanes.
- Load extraction: the selected byte or half is shifted down to bit 0, then zero-extended, or sign-extended when `req_signed`=1.
- Error cases: out-of-range (`req_addr` ≥ 4·DEPTH_WORDS) or `req_size`=11 gives `rsp_err`=1. Nothing is written and `rsp_rdata`=0.
- Stores receive a response (`rsp_valid`=1, `rsp_rdata`=0), so the requester can count completions.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, FSM=INIT, counter=0.
- INIT lasts exactly DEPTH_WORDS cycles after the first cycle with `rst` low. `req_ready` rises in the cycle after the last zero write.
- Accept at edge n → `rsp_valid`/`rsp_rdata`/`rsp_err` registered, visible during cycle n+1. `rsp_valid` drops next cycle unless another request was accepted.
- Back-to-back requests are sustained at one per cycle with no bubbles.
- Store accepted at edge n, load of the same bytes accepted at edge n+1: the load returns the new data (write at edge n precedes read).
- Partial store followed by a word load: only the enabled lanes change; the other lanes are preserved.
- `rst` asserted at any time, including mid-INIT or with a response pending:
  - Outputs return to reset values at the next edge.
  - Pending response is dropped.
  - INIT restarts from 0.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - A half access with `addr[0]`=1 or a word access with `addr[1:0]`≠00 gives `rsp_err`=1.
  - No write occurs and `rsp_rdata`=0.
- `DMEM_ALIGN_CHECK_EN` undefined:
  - Misaligned low address bits are ignored: half uses `addr[1]` only, word uses lanes 0–3.
  - Such accesses complete normally with `rsp_err`=0.

## Structure
- `dmem_pkg` holds:
  - size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - FSM state typedef (`ST_INIT`, `ST_RUN`);
  - the lane-count constant.
- One sub-module, `dmem_lane_align`: purely combinational. Produces store byte enables and replicated write data from size/addr/wdata, and extracts plus extends load data from a 32-bit word.
- `dmem_ctrl` owns the FSM, init counter, storage array, range/alignment checks and response registers.

## Test plan
- Init: release `rst`, DEPTH_WORDS=256 → `req_ready` stays low 256 cycles then rises. A word load of 0x3FC returns 0x00000000.
- Word then bytes: store word 0x8899AABB at 0x10, then signed byte load 0x11 → 0xFFFFFFAA. Unsigned half load 0x12 → 0x00008899.
- Partial store: word 0x11223344 at 0x20, byte store 0xEE at 0x22, word load 0x20 → 0x11EE3344.
- Back-to-back: store 0xCAFEF00D at 0x40 at edge n, load 0x40 at edge n+1 → `rsp_rdata`=0xCAFEF00D in cycle n+2. `rsp_valid` is high for both responses.
- Errors: load at 0x400 (DEPTH_WORDS=256) → `rsp_err`=1, `rsp_rdata`=0. Store with `req_size`=11 → `rsp_err`=1 and memory unchanged. With `DMEM_ALIGN_CHECK_EN`, a word load at 0x42 → `rsp_err`=1; without it → returns the word at 0x40.
- Reset mid-INIT at cycle 100 → `req_ready` low for a further full 256 cycles after release.
